logo_scroll_ctrl: RTL and testbench
===================================

Name: logo_scroll_ctrl

Overview:
- Animation controller that generates the horizontal offset `delt` consumed by the logo glyph painters. Every painter in the logo adds `delt` to its base X coordinate.
- Counts frames from the VGA timing generator's vsync and steps `delt` back and forth between 0 and DELT_MAX, dwelling at each end.
- Updates happen only at the vsync edge, i.e. inside vertical blank, so the logo never tears mid-frame.
- Sits between the VGA sync generator (upstream) and the glyph painters (downstream).

Parameters:
- STEP, 2: pixels added to or subtracted from `delt` per movement step; range 1..DELT_MAX.
- DELT_MAX, 100: right-hand limit of `delt`; must be ≤ 2047.
- FRAMES_PER_STEP, 2: frame ticks per movement step; must be ≥ 1.
- DWELL_FRAMES, 3: frame ticks spent stationary at each end; 0 means no dwell.
- VS_POL, 0: vsync active level; 0 means the sync pulse is active-low.

Ports:
- clk  in  1  pixel clock; same clock as the VGA timing generator.
- rst  in  1  asynchronous, active-low reset.
- vsync  in  1  vertical sync from the timing generator; synchronous to clk.
- enable  in  1  animation enable; low forces the home position.
- pause  in  1  freeze the animation in place.
- delt  out  11  horizontal offset for the glyph painters; registered.
- dir  out  1  0 = moving right / right-end dwell, 1 = moving left / left-end dwell; registered.
- step_pulse  out  1  one-cycle pulse in the cycle after `delt` changes; registered.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - delt=0, dir=0, step_pulse=0
  - state=IDLE
  - frame counter fcnt=0, dwell counter dcnt=0
  - vs_q = inactive level (~VS_POL)
- Frame tick:
  - vs_q <= vsync every cycle.
  - tick = (vs_q != VS_POL) && (vsync == VS_POL), i.e. the cycle vsync is first seen at its active level.
  - Any state update caused by a tick is visible one clock after that cycle.
- Priority (highest first): rst, then enable=0, then pause=1, then tick.
- enable=0 (synchronous): state=IDLE, delt=0, dir=0, fcnt=0, dcnt=0, step_pulse=0.
- IDLE: when enable=1, go to MOVE_R on the next clock; delt stays 0.
- pause=1 with enable=1: all state, counters and outputs hold; ticks are ignored, not queued; step_pulse=0.
- MOVE_R, on tick:
  - If fcnt≠FRAMES_PER_STEP-1: fcnt++.
  - Otherwise: fcnt=0 and a step occurs:
    - If delt+STEP ≥ DELT_MAX (sum evaluated in 12 bits): delt=DELT_MAX; next state is DWELL_R, or MOVE_L with dir=1 if DWELL_FRAMES=0.
    - Else delt=delt+STEP.
    - step_pulse=1 on the following cycle.
- MOVE_L: mirror of MOVE_R.
  - Step condition: if delt ≤ STEP then delt=0 and go to DWELL_L (or MOVE_R with dir=0); else delt=delt-STEP.
  - No underflow is possible.
- DWELL_R / DWELL_L, on tick:
  - If dcnt=DWELL_FRAMES-1: dcnt=0, fcnt=0, switch to MOVE_L (dir=1) or MOVE_R (dir=0).
  - Else dcnt++.
- `dir` flips when the dwell state is entered, not when it exits:
  - entering DWELL_R sets dir=1;
  - entering DWELL_L sets dir=0.
- Saturation: `delt` always lands exactly on DELT_MAX and exactly on 0, even when STEP does not divide DELT_MAX.
- A tick coinciding with the enable 1→0 transition is discarded.
- Holding vsync at its active level produces only one tick.

Test Plan:
- Reset, enable=1, defaults, 2 vsync pulses → after 2nd tick delt=2, dir=0, exactly one step_pulse.
- Continue to 100 ticks total → delt=100 and state DWELL_R from tick 100; dir=1 as DWELL_R is entered; delt stays 100 through ticks 101–103; tick 105 → delt=98.
- Run to left end → delt decrements to 0, holds 3 ticks, then rises to 2 with dir=0; delt is never negative or wrapped.
- DELT_MAX=5, STEP=2, FRAMES_PER_STEP=1, DWELL_FRAMES=0 → sequence 2,4,5,3,1,0,2; dir=1 as soon as delt reaches 5.
- Mid-run: pause=1 across 4 ticks → delt frozen, no step_pulse; release → resumes with the fcnt value held before the pause. Then enable=0 → delt=0, dir=0 next clock.
- Assert rst=0 asynchronously mid-step (between clock edges) → delt=0, step_pulse=0 immediately; vsync held active for 1000 cycles → single tick.

Source files
------------

// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl: frame-paced ping-pong horizontal offset for the logo painters.
// All motion is stepped on the vsync leading edge so updates land inside vertical blank.
module logo_scroll_ctrl #(
    parameter int   STEP            = 2,
    parameter int   DELT_MAX        = 100,
    parameter int   FRAMES_PER_STEP = 2,
    parameter int   DWELL_FRAMES    = 3,
    parameter logic VS_POL          = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        enable,
    input  logic        pause,
    output logic [10:0] delt,
    output logic        dir,
    output logic        step_pulse
);
    localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int DW = DWELL_FRAMES > 1 ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [DW-1:0] DLAST = DW'(DWELL_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, MOVE_R, DWELL_R, MOVE_L, DWELL_L} state_t;

    state_t        state_q, state_d;
    logic [10:0]   delt_q, delt_d;
    logic          dir_q, dir_d;
    logic          step_pulse_q, step_pulse_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          vs_q;
    logic          tick;
    logic [11:0]   sum;

    assign tick = (vs_q != VS_POL) && (vsync == VS_POL);
    assign sum  = {1'b0, delt_q} + 12'(STEP);

    always_comb begin
        state_d      = state_q;
        delt_d       = delt_q;
        dir_d        = dir_q;
        fcnt_d       = fcnt_q;
        dcnt_d       = dcnt_q;
        step_pulse_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            delt_d  = '0;
            dir_d   = 1'b0;
            fcnt_d  = '0;
            dcnt_d  = '0;
        end else if (!pause) begin
            case (state_q)
                IDLE: state_d = MOVE_R;
                MOVE_R: if (tick) begin
                    if (fcnt_q != FLAST) fcnt_d = fcnt_q + 1'b1;
                    else begin
                        fcnt_d       = '0;
                        step_pulse_d = 1'b1;
                        // Saturate so the right end is hit exactly even when STEP does not divide DELT_MAX.
                        if (sum >= 12'(DELT_MAX)) begin
                            delt_d  = 11'(DELT_MAX);
                            dir_d   = 1'b1;
                            state_d = DWELL_FRAMES == 0 ? MOVE_L : DWELL_R;
                        end else delt_d = sum[10:0];
                    end
                end
                MOVE_L: if (tick) begin
                    if (fcnt_q != FLAST) fcnt_d = fcnt_q + 1'b1;
                    else begin
                        fcnt_d       = '0;
                        step_pulse_d = 1'b1;
                        if (delt_q <= 11'(STEP)) begin
                            delt_d  = '0;
                            dir_d   = 1'b0;
                            state_d = DWELL_FRAMES == 0 ? MOVE_R : DWELL_L;
                        end else delt_d = delt_q - 11'(STEP);
                    end
                end
                DWELL_R, DWELL_L: if (tick) begin
                    if (dcnt_q == DLAST) begin
                        dcnt_d  = '0;
                        fcnt_d  = '0;
                        state_d = state_q == DWELL_R ? MOVE_L : MOVE_R;
                    end else dcnt_d = dcnt_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            delt_q       <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            fcnt_q       <= '0;
            dcnt_q       <= '0;
            vs_q         <= ~VS_POL;
        end else begin
            state_q      <= state_d;
            delt_q       <= delt_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            fcnt_q       <= fcnt_d;
            dcnt_q       <= dcnt_d;
            vs_q         <= vsync;
        end
    end

    assign delt       = delt_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// tb_logo_scroll_ctrl: randomized vsync timing checked against a closed-form position model.
// Two instances run side by side: default parameters and a small non-dividing, no-dwell set.
module tb_logo_scroll_ctrl;
    localparam int SA = 2, MA = 100, FA = 2, DA = 3;
    localparam int SB = 2, MB = 5, FB = 1, DB = 0;
    localparam logic VS_ACT = 1'b0;

    logic clk = 1'b0, rst = 1'b0, vsync = ~VS_ACT, enable = 1'b0, pause = 1'b0;
    logic [10:0] delt_a, delt_b;
    logic dir_a, dir_b, step_a, step_b;
    int checks = 0, errors = 0;
    int k = 0;
    bit seq_on = 1'b0;
    int seq_b[7] = '{2, 4, 5, 3, 1, 0, 2};

    logo_scroll_ctrl #(.STEP(SA), .DELT_MAX(MA), .FRAMES_PER_STEP(FA), .DWELL_FRAMES(DA), .VS_POL(VS_ACT)) dut_a (
        .clk(clk), .rst(rst), .vsync(vsync), .enable(enable), .pause(pause),
        .delt(delt_a), .dir(dir_a), .step_pulse(step_a));
    logo_scroll_ctrl #(.STEP(SB), .DELT_MAX(MB), .FRAMES_PER_STEP(FB), .DWELL_FRAMES(DB), .VS_POL(VS_ACT)) dut_b (
        .clk(clk), .rst(rst), .vsync(vsync), .enable(enable), .pause(pause),
        .delt(delt_b), .dir(dir_b), .step_pulse(step_b));

    always #5 clk = ~clk;

    // One period = climb (n*f ticks), right dwell, descent, left dwell; position follows from k mod period.
    function automatic void model(input int kk, input int st, input int mx, input int f, input int d,
                                  output int dl, output bit dr);
        int n, nf, m;
        n  = (mx + st - 1) / st;
        nf = n * f;
        m  = kk % (2 * (nf + d));
        if (m < nf) begin dl = (m / f) * st; dr = 1'b0; end
        else if (m < nf + d) begin dl = mx; dr = 1'b1; end
        else if (m < 2 * nf + d) begin dl = mx - ((m - nf - d) / f) * st; dr = 1'b1; end
        else begin dl = 0; dr = 1'b0; end
    endfunction

    task automatic tick_and_check(input bit paused);
        int pa, pb, ea, eb;
        bit xa, xb, da, db;
        model(k, SA, MA, FA, DA, pa, xa);
        model(k, SB, MB, FB, DB, pb, xb);
        if (!paused) k++;
        model(k, SA, MA, FA, DA, ea, da);
        model(k, SB, MB, FB, DB, eb, db);
        @(negedge clk) vsync = VS_ACT;
        @(negedge clk);
        checks += 6;
        if (delt_a !== 11'(ea)) begin errors++; $display("FAIL delt_a k=%0d got %0d want %0d", k, delt_a, ea); end
        if (dir_a !== da) begin errors++; $display("FAIL dir_a k=%0d got %0b want %0b", k, dir_a, da); end
        if (step_a !== (ea != pa)) begin errors++; $display("FAIL step_a k=%0d got %0b want %0b", k, step_a, ea != pa); end
        if (delt_b !== 11'(eb)) begin errors++; $display("FAIL delt_b k=%0d got %0d want %0d", k, delt_b, eb); end
        if (dir_b !== db) begin errors++; $display("FAIL dir_b k=%0d got %0b want %0b", k, dir_b, db); end
        if (step_b !== (eb != pb)) begin errors++; $display("FAIL step_b k=%0d got %0b want %0b", k, step_b, eb != pb); end
        if (seq_on && k >= 1 && k <= 7) begin
            checks++;
            if (delt_b !== 11'(seq_b[k-1])) begin errors++; $display("FAIL seq_b k=%0d got %0d want %0d", k, delt_b, seq_b[k-1]); end
        end
        @(negedge clk);
        checks++;
        if (step_a !== 1'b0 || step_b !== 1'b0) begin errors++; $display("FAIL pulse_width k=%0d got %0b%0b want 00", k, step_a, step_b); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        vsync = ~VS_ACT;
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk) enable = 1'b1;
        repeat (2) @(negedge clk);
        k = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 2;
        if (delt_a !== 11'd0 || dir_a !== 1'b0 || step_a !== 1'b0) begin
            errors++; $display("FAIL reset_a got delt=%0d dir=%0b pulse=%0b want 0 0 0", delt_a, dir_a, step_a);
        end
        if (delt_b !== 11'd0 || dir_b !== 1'b0 || step_b !== 1'b0) begin
            errors++; $display("FAIL reset_b got delt=%0d dir=%0b pulse=%0b want 0 0 0", delt_b, dir_b, step_b);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_first_steps();
        seq_on = 1'b1;
        restart();
        repeat (2) tick_and_check(1'b0);
    endtask

    task automatic test_right_end();
        while (k < 105) tick_and_check(1'b0);
    endtask

    task automatic test_left_end();
        while (k < 215) tick_and_check(1'b0);
    endtask

    task automatic test_pause();
        logic [10:0] ha, hb;
        if (k % 2 == 0) tick_and_check(1'b0);
        @(negedge clk) pause = 1'b1;
        ha = delt_a;
        hb = delt_b;
        repeat (4) tick_and_check(1'b1);
        checks++;
        if (delt_a !== ha || delt_b !== hb) begin
            errors++; $display("FAIL pause_hold got %0d/%0d want %0d/%0d", delt_a, delt_b, ha, hb);
        end
        @(negedge clk) pause = 1'b0;
        repeat (6) tick_and_check(1'b0);
    endtask

    task automatic test_disable();
        seq_on = 1'b0;
        @(negedge clk) begin enable = 1'b0; vsync = VS_ACT; end
        @(negedge clk);
        checks += 2;
        if (delt_a !== 11'd0 || dir_a !== 1'b0 || step_a !== 1'b0) begin
            errors++; $display("FAIL disable_a got delt=%0d dir=%0b pulse=%0b want 0 0 0", delt_a, dir_a, step_a);
        end
        if (delt_b !== 11'd0 || dir_b !== 1'b0 || step_b !== 1'b0) begin
            errors++; $display("FAIL disable_b got delt=%0d dir=%0b pulse=%0b want 0 0 0", delt_b, dir_b, step_b);
        end
        vsync = ~VS_ACT;
        restart();
        repeat (5) tick_and_check(1'b0);
    endtask

    task automatic test_async_reset_and_held_vsync();
        int pulses = 0;
        @(negedge clk) vsync = VS_ACT;
        @(posedge clk);
        #2;
        checks++;
        if (step_b !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse got %0b want 1", step_b); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (delt_a !== 11'd0 || step_a !== 1'b0 || delt_b !== 11'd0 || step_b !== 1'b0) begin
            errors++; $display("FAIL async_reset got %0d/%0b %0d/%0b want 0/0 0/0", delt_a, step_a, delt_b, step_b);
        end
        if (dir_a !== 1'b0 || dir_b !== 1'b0) begin
            errors++; $display("FAIL async_reset_dir got %0b%0b want 00", dir_a, dir_b);
        end
        @(negedge clk) vsync = ~VS_ACT;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        vsync = VS_ACT;
        repeat (1000) begin
            @(negedge clk);
            if (step_b === 1'b1) pulses++;
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL held_vsync_pulses got %0d want 1", pulses); end
        if (delt_b !== 11'd2) begin errors++; $display("FAIL held_vsync_b got %0d want 2", delt_b); end
        if (delt_a !== 11'd0) begin errors++; $display("FAIL held_vsync_a got %0d want 0", delt_a); end
        vsync = ~VS_ACT;
        repeat (2) @(negedge clk);
        k = 1;
        repeat (3) tick_and_check(1'b0);
    endtask

    initial begin
        test_reset();
        test_first_steps();
        test_right_end();
        test_left_end();
        test_pause();
        test_disable();
        test_async_reset_and_held_vsync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
